fp_mult_responder: RTL and testbench

- Single-precision IEEE-754 floating-point multiplier that serves the mult_start / mult_operand_a / mult_operand_b -> mult_result_ready / mult_result handshake issued by the expression evaluator and the term accumulator.
- Multi-cycle, one operation in flight at a time.
- Sits alongside the adder, divider and exponent units in the arithmetic pool.

---
 rtl/fp_mult_responder.sv | 222 ++++++++++++++++++++++
 tb/tb_fp_mult_responder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_mult_responder.sv
// Multi-cycle IEEE-754 single-precision multiplier (unpack/mult/norm/round), one op in flight.
// Define FP_MULT_FLAGS_EN to add sticky {invalid, overflow, underflow} flags on mult_flags.
module fp_mult_responder #(
  parameter int EXP_LEN      = 8,
  parameter int MANTISSA_LEN = 23,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mult_start,
  input  logic [DATA_WIDTH-1:0] mult_operand_a,
  input  logic [DATA_WIDTH-1:0] mult_operand_b,
  output logic [DATA_WIDTH-1:0] mult_result,
  output logic                  mult_result_ready,
  output logic                  mult_busy
`ifdef FP_MULT_FLAGS_EN
  ,
  output logic [2:0]            mult_flags
`endif
);

  // state | meaning
  // IDLE  | waiting for mult_start, operands latched on accept
  // UNPACK| classify operands, sign, biased exponent sum
  // MULT  | significand product
  // NORM  | normalize product, extract guard/round/sticky
  // ROUND | round-to-nearest-even, specials, publish result
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_UNPACK = 3'd1;
  localparam logic [2:0] S_MULT   = 3'd2;
  localparam logic [2:0] S_NORM   = 3'd3;
  localparam logic [2:0] S_ROUND  = 3'd4;

  localparam int MW = MANTISSA_LEN + 1;
  localparam int PW = 2 * MW;
  localparam int EW = EXP_LEN + 2;

  localparam logic [EXP_LEN-1:0]        EXP_ONES = '1;
  localparam logic signed [EW-1:0]      BIAS     = EW'((1 << (EXP_LEN - 1)) - 1);
  localparam logic signed [EW-1:0]      EXP_MAX  = EW'((1 << EXP_LEN) - 1);
  localparam logic [DATA_WIDTH-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MANTISSA_LEN-1){1'b0}}};

  logic [2:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
  logic                  sign_q, sign_d;
  logic signed [EW-1:0]  exp_q, exp_d;
  logic [MW-1:0]         mant_a_q, mant_a_d, mant_b_q, mant_b_d;
  logic                  nan_q, nan_d, inf_q, inf_d, zero_q, zero_d;
  logic [PW-1:0]         prod_q, prod_d;
  logic [MW-1:0]         mant_q, mant_d;
  logic                  guard_q, guard_d, rnd_q, rnd_d, sticky_q, sticky_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  ready_q, ready_d, busy_q, busy_d;
`ifdef FP_MULT_FLAGS_EN
  logic [2:0]            flags_q, flags_d;
`endif

  logic [EXP_LEN-1:0]      ea, eb;
  logic [MANTISSA_LEN-1:0] fa, fb;
  logic                    round_up, invalid, ovf, unf;
  logic [MW:0]             mant_sum;
  logic signed [EW-1:0]    exp_r;
  logic [MANTISSA_LEN-1:0] frac_r;

  assign ea = opa_q[DATA_WIDTH-2 -: EXP_LEN];
  assign eb = opb_q[DATA_WIDTH-2 -: EXP_LEN];
  assign fa = opa_q[MANTISSA_LEN-1:0];
  assign fb = opb_q[MANTISSA_LEN-1:0];

  // Rounding carry leaves an all-zero fraction, so the shifted view is exact.
  assign round_up = guard_q & (rnd_q | sticky_q | mant_q[0]);
  assign mant_sum = {1'b0, mant_q} + (MW+1)'(round_up);
  assign exp_r    = exp_q + EW'(mant_sum[MW]);
  assign frac_r   = mant_sum[MW] ? mant_sum[MW-1:1] : mant_sum[MANTISSA_LEN-1:0];
  assign invalid  = nan_q | (inf_q & zero_q);
  assign ovf      = exp_r >= EXP_MAX;
  assign unf      = exp_r <= 0;

  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mant_a_d = mant_a_q;
    mant_b_d = mant_b_q;
    nan_d    = nan_q;
    inf_d    = inf_q;
    zero_d   = zero_q;
    prod_d   = prod_q;
    mant_d   = mant_q;
    guard_d  = guard_q;
    rnd_d    = rnd_q;
    sticky_d = sticky_q;
    result_d = result_q;
    ready_d  = 1'b0;
    busy_d   = busy_q;
`ifdef FP_MULT_FLAGS_EN
    flags_d  = flags_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (mult_start) begin
          opa_d   = mult_operand_a;
          opb_d   = mult_operand_b;
          busy_d  = 1'b1;
          state_d = S_UNPACK;
        end else begin
          busy_d = 1'b0;
        end
      end
      S_UNPACK: begin
        sign_d   = opa_q[DATA_WIDTH-1] ^ opb_q[DATA_WIDTH-1];
        exp_d    = {2'b00, ea} + {2'b00, eb} - BIAS;
        mant_a_d = {1'b1, fa};
        mant_b_d = {1'b1, fb};
        // Exponent field zero covers both true zero and flushed denormals.
        zero_d   = (ea == '0) | (eb == '0);
        inf_d    = ((ea == EXP_ONES) & (fa == '0)) | ((eb == EXP_ONES) & (fb == '0));
        nan_d    = ((ea == EXP_ONES) & (fa != '0)) | ((eb == EXP_ONES) & (fb != '0));
        state_d  = S_MULT;
      end
      S_MULT: begin
        prod_d  = PW'(mant_a_q) * PW'(mant_b_q);
        state_d = S_NORM;
      end
      S_NORM: begin
        if (prod_q[PW-1]) begin
          mant_d   = prod_q[PW-1:PW-MW];
          guard_d  = prod_q[PW-MW-1];
          rnd_d    = prod_q[PW-MW-2];
          sticky_d = |prod_q[PW-MW-3:0];
          exp_d    = exp_q + EW'(1);
        end else begin
          mant_d   = prod_q[PW-2:PW-MW-1];
          guard_d  = prod_q[PW-MW-2];
          rnd_d    = prod_q[PW-MW-3];
          sticky_d = |prod_q[PW-MW-4:0];
        end
        state_d = S_ROUND;
      end
      S_ROUND: begin
        if (invalid)
          result_d = QNAN;
        else if (inf_q)
          result_d = {sign_q, EXP_ONES, {MANTISSA_LEN{1'b0}}};
        else if (zero_q)
          result_d = {sign_q, {(DATA_WIDTH-1){1'b0}}};
        else if (ovf)
          result_d = {sign_q, EXP_ONES, {MANTISSA_LEN{1'b0}}};
        else if (unf)
          result_d = {sign_q, {(DATA_WIDTH-1){1'b0}}};
        else
          result_d = {sign_q, exp_r[EXP_LEN-1:0], frac_r};
`ifdef FP_MULT_FLAGS_EN
        flags_d = flags_q | {invalid,
                             ~invalid & ~inf_q & ~zero_q & ovf,
                             ~invalid & ~inf_q & ~zero_q & ~ovf & unf};
`endif
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mant_a_q <= '0;
      mant_b_q <= '0;
      nan_q    <= 1'b0;
      inf_q    <= 1'b0;
      zero_q   <= 1'b0;
      prod_q   <= '0;
      mant_q   <= '0;
      guard_q  <= 1'b0;
      rnd_q    <= 1'b0;
      sticky_q <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
`ifdef FP_MULT_FLAGS_EN
      flags_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mant_a_q <= mant_a_d;
      mant_b_q <= mant_b_d;
      nan_q    <= nan_d;
      inf_q    <= inf_d;
      zero_q   <= zero_d;
      prod_q   <= prod_d;
      mant_q   <= mant_d;
      guard_q  <= guard_d;
      rnd_q    <= rnd_d;
      sticky_q <= sticky_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
`ifdef FP_MULT_FLAGS_EN
      flags_q  <= flags_d;
`endif
    end
  end

  assign mult_result       = result_q;
  assign mult_result_ready = ready_q;
  assign mult_busy         = busy_q;
`ifdef FP_MULT_FLAGS_EN
  assign mult_flags        = flags_q;
`endif

endmodule

// File: tb/tb_fp_mult_responder.sv
// Directed bench for fp_mult_responder; results checked against a queue of expected products.
module tb_fp_mult_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] op_a, op_b;
  logic [31:0] result;
  logic        ready, busy;
`ifdef FP_MULT_FLAGS_EN
  logic [2:0]  flags;
`endif

  int checks = 0;
  int errors = 0;
  int ready_count = 0;
  logic prev_ready = 1'b0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  fp_mult_responder dut (
    .clock             (clk),
    .reset             (rst_n),
    .mult_start        (start),
    .mult_operand_a    (op_a),
    .mult_operand_b    (op_b),
    .mult_result       (result),
    .mult_result_ready (ready),
    .mult_busy         (busy)
`ifdef FP_MULT_FLAGS_EN
    ,
    .mult_flags        (flags)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one start pulse at a falling edge; accepted on the next rising edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input bit push);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    if (push) sb.push_back(exp);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (ready !== 1'b1 && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, ready}, 32'd1);
  endtask

  always @(negedge clk) begin
    if (ready === 1'b1) begin
      ready_count++;
      chk("ready_not_back_to_back", {31'd0, prev_ready}, 32'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_ready: observed result %h with empty scoreboard", result);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        chk("result", result, e);
      end
    end
    prev_ready = ready;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_ready;
    int busy_cnt;
    int rc0;

    rst_n = 1'b0;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    repeat (3) @(negedge clk);
    chk("reset_result", result, 32'h0);
    chk("reset_ready", {31'd0, ready}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
`ifdef FP_MULT_FLAGS_EN
    chk("reset_flags", {29'd0, flags}, 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // 2.0 * 3.0: latency and busy window
    op_a  = 32'h40000000;
    op_b  = 32'h40400000;
    start = 1'b1;
    sb.push_back(32'h40C00000);
    first_ready = -1;
    busy_cnt    = 0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (busy === 1'b1) busy_cnt++;
      if (ready === 1'b1 && first_ready < 0) first_ready = i;
    end
    chk("latency_edges", first_ready, 5);
    chk("busy_cycles", busy_cnt, 5);

    // 1.5 * 1.5, then back-to-back start in the ready cycle
    start_op(32'h3FC00000, 32'h3FC00000, 32'h40100000, 1);
    wait_ready("ready_1p5sq");
    chk("busy_in_ready_cycle", {31'd0, busy}, 32'd1);
    start_op(32'hC0000000, 32'h3F000000, 32'hBF800000, 1);
    wait_ready("ready_b2b");

    // rounding and overflow
    @(negedge clk);
    start_op(32'h3F800001, 32'h3F800001, 32'h3F800002, 1);
    wait_ready("ready_round");
    @(negedge clk);
    start_op(32'h7F000000, 32'h40000000, 32'h7F800000, 1);
    wait_ready("ready_ovf");
`ifdef FP_MULT_FLAGS_EN
    chk("flags_ovf", {29'd0, flags}, 32'd2);
`endif

    // specials
    @(negedge clk);
    start_op(32'h7F800000, 32'h00000000, 32'h7FC00000, 1);
    wait_ready("ready_inf_zero");
`ifdef FP_MULT_FLAGS_EN
    chk("flags_invalid", {29'd0, flags}, 32'd6);
`endif
    @(negedge clk);
    start_op(32'h00800000, 32'h3F000000, 32'h00000000, 1);
    wait_ready("ready_unf");
`ifdef FP_MULT_FLAGS_EN
    chk("flags_unf", {29'd0, flags}, 32'd7);
`endif
    @(negedge clk);
    start_op(32'h80000000, 32'h40000000, 32'h80000000, 1);
    wait_ready("ready_negzero");
    chk("result_holds", result, 32'h80000000);
    @(negedge clk);
    chk("result_held_after_ready", result, 32'h80000000);

    // start held high for six edges with changing operands
    rc0 = ready_count;
    sb.push_back(32'h40000000);
    sb.push_back(32'h40C00000);
    start = 1'b1;
    for (int j = 0; j < 6; j++) begin
      if (j == 0) begin
        op_a = 32'h3F800000; op_b = 32'h40000000;
      end else if (j == 5) begin
        op_a = 32'h40400000; op_b = 32'h40000000;
      end else begin
        op_a = 32'h41000000 + 32'(j); op_b = 32'h41000000;
      end
      @(negedge clk);
    end
    start = 1'b0;
    op_a  = 32'hDEADBEEF;
    op_b  = 32'h12345678;
    repeat (12) @(negedge clk);
    chk("held_start_pulses", ready_count - rc0, 2);
    chk("held_start_sb_empty", sb.size(), 0);

    // reset during MULT abandons the operation
    rc0 = ready_count;
    start_op(32'h40000000, 32'h40000000, 32'h0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midreset_result", result, 32'h0);
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_ready", {31'd0, ready}, 32'd0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("midreset_no_pulse", ready_count - rc0, 0);
    start_op(32'h3F800000, 32'h3F800000, 32'h3F800000, 1);
    wait_ready("ready_after_reset");
    @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
